// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST controller.
// The LFSR and the MISR share one polynomial, x^16+x^14+x^13+x^11+1.
package gate_bist_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      APPLY   = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } bist_state_t;

   localparam int LFSR_W = 16;
   localparam logic [LFSR_W-1:0] POLY_TAPS = 16'hB400;  // bits 15,13,12,10
   localparam logic [LFSR_W-1:0] SEED_FIX  = 16'h0001;

   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] r);
      return ^(r & POLY_TAPS);
   endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit shift register with polynomial feedback and a parallel XOR input;
// tie pin to zero for a pattern generator, feed responses in for a MISR.
module bist_lfsr16
   import gate_bist_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [LFSR_W-1:0] pin,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= RST_VAL;
      end else if (load) begin
         value <= seed;
      end else if (step) begin
         value <= {value[LFSR_W-2:0], lfsr_fb(value)} ^ pin;
      end
   end

endmodule

// File: rtl/gate_bist_controller.sv
// BIST driver for one combinational gate model: LFSR patterns in, settle,
// compact responses into a MISR signature and compare against a golden value.
module gate_bist_controller
   import gate_bist_pkg::*;
#(
   parameter int NUM_IN    = 14,
   parameter int NUM_OUT   = 10,
   parameter int PAT_COUNT = 1024,
   parameter int SETTLE    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [LFSR_W-1:0]  seed,
   input  logic [LFSR_W-1:0]  exp_sig,
   output logic [NUM_IN-1:0]  dut_in,
   input  logic [NUM_OUT-1:0] dut_out,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [LFSR_W-1:0]  signature,
   output bist_state_t        dbg_state
);

   localparam int CW = $clog2(PAT_COUNT + 1);
   localparam int SW = $clog2(SETTLE + 1);

   bist_state_t       state, state_nx;
   logic [LFSR_W-1:0] lfsr, misr, load_seed, misr_pin;
   logic [CW-1:0]     pat_cnt, pat_nx;
   logic [SW-1:0]     set_cnt;
   logic              gen_load, gen_step, misr_load, misr_step;
   logic              settled, last_pat, drive;

   assign load_seed = (seed == '0) ? SEED_FIX : seed;
   assign misr_pin  = LFSR_W'(dut_out);
   assign pat_nx    = pat_cnt + CW'(1);
   assign settled   = (set_cnt == SW'(SETTLE - 1));
   assign last_pat  = (pat_nx == CW'(PAT_COUNT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Abort takes precedence over every transition and wipes the signature.
   always_comb begin
      state_nx  = state;
      gen_load  = 1'b0;
      gen_step  = 1'b0;
      misr_load = 1'b0;
      misr_step = 1'b0;
      if (abort) begin
         state_nx  = IDLE;
         misr_load = 1'b1;
      end else begin
         case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD: begin
               gen_load  = 1'b1;
               misr_load = 1'b1;
               state_nx  = APPLY;
            end
            APPLY:   if (settled) state_nx = CAPTURE;
            CAPTURE: begin
               gen_step  = 1'b1;
               misr_step = 1'b1;
               state_nx  = last_pat ? DONE : APPLY;
            end
            DONE:    if (start) state_nx = LOAD;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_cnt <= '0;
         set_cnt <= '0;
      end else if (abort || state == LOAD) begin
         pat_cnt <= '0;
         set_cnt <= '0;
      end else if (state == APPLY) begin
         set_cnt <= set_cnt + SW'(1);
      end else if (state == CAPTURE) begin
         set_cnt <= '0;
         pat_cnt <= pat_nx;
      end
   end

   bist_lfsr16 #(.RST_VAL(SEED_FIX)) u_gen (
      .clk   (clk),
      .rst   (rst),
      .load  (gen_load),
      .step  (gen_step),
      .pin   ('0),
      .seed  (load_seed),
      .value (lfsr)
   );

   bist_lfsr16 #(.RST_VAL('0)) u_misr (
      .clk   (clk),
      .rst   (rst),
      .load  (misr_load),
      .step  (misr_step),
      .pin   (misr_pin),
      .seed  ('0),
      .value (misr)
   );

   assign drive     = (state == APPLY) || (state == CAPTURE);
   assign dut_in    = drive ? lfsr[NUM_IN-1:0] : '0;
   assign busy      = (state == LOAD) || drive;
   assign done      = (state == DONE);
   assign pass      = done && (misr == exp_sig);
   assign signature = misr;
   assign dbg_state = state;

endmodule

// File: tb/tb_gate_bist_controller.sv
// Bench for gate_bist_controller: random runs scored against a behavioural
// pattern/signature model, plus reset, abort, loopback and restart cases.
module tb_gate_bist_controller;
   import gate_bist_pkg::*;

   localparam int NI = 14;
   localparam int NO = 10;
   localparam int PC = 4;
   localparam int ST = 2;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main instance
   logic start, abort;
   logic [15:0] seed, exp_sig, signature;
   logic [NI-1:0] dut_in;
   logic [NO-1:0] dut_out;
   logic busy, done, pass;
   bist_state_t dbg_state;
   int mode;

   // single-pattern loopback instance
   logic start1;
   logic abort1 = 1'b0;
   logic [15:0] seed1 = 16'h0001;
   logic [15:0] exp_sig1, signature1;
   logic [NI-1:0] dut_in1;
   logic [NO-1:0] dut_out1;
   logic busy1, done1, pass1;
   bist_state_t dbg_state1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0] sig;
      logic        pass;
      int unsigned t0;
   } exp_t;
   exp_t exp_q[$];

   gate_bist_controller #(.NUM_IN(NI), .NUM_OUT(NO), .PAT_COUNT(PC), .SETTLE(ST)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
      .exp_sig(exp_sig), .dut_in(dut_in), .dut_out(dut_out), .busy(busy),
      .done(done), .pass(pass), .signature(signature), .dbg_state(dbg_state)
   );

   gate_bist_controller #(.NUM_IN(NI), .NUM_OUT(NO), .PAT_COUNT(1), .SETTLE(1)) u_one (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .seed(seed1),
      .exp_sig(exp_sig1), .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1),
      .done(done1), .pass(pass1), .signature(signature1), .dbg_state(dbg_state1)
   );

   // gate models driven by the bench
   function automatic logic [NO-1:0] gate_fn(input logic [NI-1:0] p, input int m);
      case (m)
         0:       return '0;
         1:       return p[9:0];
         default: return {p[13:10], p[5:0]} ^ (p[9:0] & p[13:4]);
      endcase
   endfunction

   always_comb dut_out  = gate_fn(dut_in, mode);
   always_comb dut_out1 = dut_in1[9:0];

   // reference model: walk the pattern list and fold each response in
   function automatic logic par(input logic [15:0] x);
      return x[15] ^ x[13] ^ x[12] ^ x[10];
   endfunction

   function automatic logic [15:0] model_sig(input logic [15:0] s, input int m);
      logic [15:0] l, sig;
      l   = (s == 16'h0000) ? 16'h0001 : s;
      sig = 16'h0000;
      for (int p = 0; p < PC; p++) begin
         sig = {sig[14:0], par(sig)} ^ {6'h00, gate_fn(l[13:0], m)};
         l   = {l[14:0], par(l)};
      end
      return sig;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // driver tasks (inputs change on the falling edge)
   task automatic start_run(input logic [15:0] s, input logic [15:0] es, input int m);
      exp_t e;
      @(negedge clk);
      seed    = s;
      exp_sig = es;
      mode    = m;
      start   = 1'b1;
      e.sig   = model_sig(s, m);
      e.pass  = (es == e.sig);
      e.t0    = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got done=0, expected done=1 within 200 cycles");
      end
   endtask

   // monitor / scoreboard
   initial begin
      logic done_q;
      int   busy_cnt;
      exp_t e;
      done_q   = 1'b0;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst || abort) busy_cnt = 0;
         else if (busy)    busy_cnt++;
         if (done && !done_q) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1, expected no pending run");
            end else begin
               e = exp_q.pop_front();
               check("signature", signature, e.sig);
               check("pass", pass, e.pass);
               check("done_latency", cyc - e.t0, 2 + PC * (ST + 1));
               check("busy_cycles", busy_cnt, 1 + PC * (ST + 1));
            end
            busy_cnt = 0;
         end
         done_q = done;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no end of test, expected finish before 300000");
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      logic [15:0] s, es, good;
      int m;
      rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; exp_sig = '0; mode = 0;
      start1 = 1'b0; exp_sig1 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_sig", signature, 0);
      check("rst_dut_in", dut_in, 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      rst = 1'b0;

      // zero seed falls back to 1; zero responses give a zero signature
      start_run(16'h0000, 16'h0000, 0);
      for (int p = 0; p < PC; p++) begin
         logic [NI-1:0] want;
         want = 1;
         want = want << p;
         @(negedge clk);
         check("pattern", dut_in, want);
         repeat (2) @(negedge clk);
      end
      wait_done();

      // loopback, then restart from DONE with a wrong golden, then repeat
      start_run(16'h0001, 16'h0000, 1);
      wait_done();
      start_run(16'h0001, 16'h1234, 1);
      wait_done();
      start_run(16'h0001, 16'h0000, 1);
      wait_done();

      // single-pattern loopback instance
      @(negedge clk);
      exp_sig1 = 16'h0001;
      start1   = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (3) @(negedge clk);
      check("one_done", done1, 1);
      check("one_state", 32'(dbg_state1), 32'(DONE));
      check("one_busy", busy1, 0);
      check("one_sig", signature1, 16'h0001);
      check("one_pass", pass1, 1);
      exp_sig1 = 16'h1234;
      @(negedge clk);
      check("one_pass_bad", pass1, 0);

      // abort in the third APPLY cycle
      start_run(16'hACE1, 16'h0000, 2);
      repeat (4) @(negedge clk);
      abort = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sig", signature, 0);
      check("abort_state", 32'(dbg_state), 32'(IDLE));
      start = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_start_state", 32'(dbg_state), 32'(IDLE));
      check("abort_start_busy", busy, 0);
      start = 1'b0;
      abort = 1'b0;

      // asynchronous reset mid-APPLY
      start_run(16'h5A5A, 16'h0000, 2);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_sig", signature, 0);
      check("midrst_dut_in", dut_in, 0);
      check("midrst_state", 32'(dbg_state), 32'(IDLE));
      void'(exp_q.pop_back());
      @(negedge clk);
      rst = 1'b0;

      // random runs, some with a start pulse while busy
      for (int i = 0; i < 12; i++) begin
         s    = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         m    = int'($urandom_range(0, 2));
         good = model_sig(s, m);
         es   = ($urandom_range(0, 1) == 1) ? good : good ^ 16'($urandom_range(1, 65535));
         start_run(s, es, m);
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         wait_done();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
